// File: rtl/rr_arbiter_8x3.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_8x3
// Brief    : Round-robin arbiter, 8 requesters, binary + one-hot grant with a
//            bounded hold tenure and a one-cycle timeout pulse.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_8x3 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);

    localparam logic [7:0] c_hold_max = 8'(HOLD_MAX);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_last_idx;
    logic [7:0] r_tenure;

    logic [2:0] w_cand;
    logic [2:0] w_winner;
    logic       w_found;
    logic       w_release;
    logic       w_expire;

    // Search begins just past the previous grantee and ends on it, so the
    // previous grantee always has the lowest priority.
    always_comb begin
        w_cand   = '0;
        w_winner = r_last_idx;
        w_found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last_idx + 3'(k);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_release = done || !req[gnt_idx];
    assign w_expire  = (r_tenure == c_hold_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_idx <= 3'd7;
            r_tenure   <= 8'd0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= 3'd0;
            gnt_onehot <= 8'h00;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= w_winner;
                        gnt_onehot <= 8'd1 << w_winner;
                        r_tenure   <= 8'd1;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release || w_expire) begin
                        // A voluntary release wins over a coincident expiry.
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= 8'h00;
                        r_last_idx <= gnt_idx;
                        r_tenure   <= 8'd0;
                        timeout    <= !w_release;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tenure <= r_tenure + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8x3.md
Name: rr_arbiter_8x3

Overview:
- Round-robin arbiter that shares one encoded-index resource (the 8x3 encoder datapath) between 8 requesters.
- Samples an 8-bit request vector and grants exactly one requester at a time.
- Presents the grant as a 3-bit binary index (encoder-style Z2..Z0 ordering) plus a one-hot copy.
- Bounds each tenure with a hold timeout, so a stuck requester cannot starve the others.

Parameters:
- HOLD_MAX, 15, maximum consecutive cycles one grant may stay asserted; legal 1..255; 8-bit tenure counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; req[i] high = requester i wants the resource.
- done  input  1  current grantee releases the resource; sampled only while gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- gnt_idx  output  3  binary index of the granted requester (bit 2 = MSB).
- gnt_onehot  output  8  one-hot of gnt_idx while gnt_valid=1, else 8'h00.
- timeout  output  1  one-cycle pulse; previous grant was revoked by HOLD_MAX expiry.

Behaviour:
- Reset (async assert, sync deassert assumed by system):
  - gnt_valid=0, gnt_idx=3'd0, gnt_onehot=8'h00, timeout=0.
  - Tenure counter = 0, state = IDLE.
  - last_idx = 3'd7, so requester 0 has top priority after reset.
- States: IDLE, GRANT. All outputs are registered.
- IDLE, at each edge:
  - If req == 0: stay IDLE.
  - Else:
    - Winner = first i with req[i]=1, searching last_idx+1, last_idx+2, … wrapping mod 8 and ending at last_idx itself.
    - Register gnt_valid=1, gnt_idx=winner, gnt_onehot=1<<winner, counter=1; go to GRANT.
  - Latency: grant visible the cycle after req is first sampled high.
  - done is ignored in IDLE.
- GRANT, at each edge, in priority order:
  1. done=1 or req[gnt_idx]=0 → release, timeout stays 0.
  2. Else counter == HOLD_MAX → release and set timeout=1 for exactly one cycle.
  3. Else counter += 1, hold grant.
- Release edge:
  - gnt_valid=0, gnt_onehot=8'h00, last_idx=gnt_idx.
  - gnt_idx holds its last value.
  - counter=0, state = IDLE.
- Mandatory gap: at least one cycle with gnt_valid=0 between any two grants, including regrant of the same requester.
- Tenure bounds:
  - Grant lasts at most HOLD_MAX cycles.
  - With HOLD_MAX=1, each grant lasts exactly 1 cycle unless released earlier.
- Simultaneous events:
  - done and timeout condition in the same cycle → normal release, no timeout pulse.
  - req changes on non-granted lines during GRANT → no effect until next IDLE evaluation.
- Fairness: a lone requester is regranted after each gap; with N active requesters, each is served within N grants.
- timeout is high only in the IDLE cycle immediately following a timeout release; cleared at the next edge.
- Reset mid-GRANT: outputs drop to reset values immediately (asynchronous), last_idx returns to 7.

Test Plan:
- Post-reset arbitration: reset, then req=8'b1000_0001 → one cycle later gnt_valid=1, gnt_idx=0, gnt_onehot=8'h01; done=1 for one cycle → gap cycle → gnt_idx=7.
- Rotation: req=8'hFF held, done pulsed in every grant cycle → gnt_idx sequence 0,1,2,3,4,5,6,7,0 with one idle cycle between each grant; timeout never asserts.
- Timeout: HOLD_MAX=4, only req[3]=1, done=0 → gnt_valid high exactly 4 cycles with gnt_idx=3; then one cycle gnt_valid=0 with timeout=1; then regrant of 3.
- Early drop: req=8'h20 granted (idx 5), req[5] deasserted after 2 cycles → gnt_valid low next edge, timeout=0; done pulse while IDLE → no effect.
- Simultaneous done/expiry: HOLD_MAX=2, done asserted in cycle 2 of the grant → release with timeout=0.
- Reset mid-grant: drive rst_n=0 while gnt_idx=6 → gnt_valid=0 and gnt_onehot=8'h00 without waiting for a clock edge; after release with req=8'hC1 → first grant is idx 0.
